// File: rtl/rti_core.sv
// rtl/rti_core.sv - timestamping capture FIFO; optional change detect via RTI_CHANGE_DETECT_EN
module rti_core #(
   parameter int DEPTH      = 1024,
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     auto_start,
   input  logic                     sample_valid,
   input  logic [DATA_WIDTH-1:0]    sample_in,
   input  logic [63:0]              counter,
   input  logic                     read,
   output logic [64+DATA_WIDTH-1:0] rti_out,
   output logic                     empty,
   output logic                     full,
   output logic [CNT_WIDTH-1:0]     count,
   output logic                     overflow_error,
   output logic [64+DATA_WIDTH-1:0] overflow_error_data,
   output logic                     underflow_error
);

   localparam int ADDR = $clog2(DEPTH);
   localparam int EW   = 64 + DATA_WIDTH;

   logic [EW-1:0]        mem [DEPTH];
   logic [ADDR-1:0]      wr_ptr;
   logic [ADDR-1:0]      rd_ptr;
   logic [ADDR-1:0]      rd_next;
   logic [CNT_WIDTH-1:0] count_next;
   logic [EW-1:0]        head_next;
   logic [EW-1:0]        entry;
   logic                 cap;
   logic                 do_write;
   logic                 do_read;

   assign entry = {counter, sample_in};

`ifdef RTI_CHANGE_DETECT_EN
   logic [DATA_WIDTH-1:0] last_data;
   logic                  first_flag;

   // A sample only counts as a capture when it differs from the last one seen
   assign cap = sample_valid && auto_start && (first_flag || (sample_in != last_data));

   // Track the most recent captured-or-dropped sample; history restarts on reset/flush
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         last_data  <= '0;
         first_flag <= 1'b1;
      end else if (cap) begin
         last_data  <= sample_in;
         first_flag <= 1'b0;
      end
   end
`else
   assign cap = sample_valid && auto_start;
`endif

   assign do_write = cap && !full;
   assign do_read  = read && !empty;

   // Next fill level, next read address and next head entry for the FWFT output
   always_comb begin
      count_next = count;
      rd_next    = rd_ptr;
      head_next  = rti_out;
      if (do_write && !do_read)
         count_next = count + CNT_WIDTH'(1);
      else if (do_read && !do_write)
         count_next = count - CNT_WIDTH'(1);
      if (do_read)
         rd_next = rd_ptr + ADDR'(1);
      // The incoming entry becomes the head when nothing older remains after this cycle's read
      if (do_write && (empty || (do_read && count == CNT_WIDTH'(1))))
         head_next = entry;
      else if (count_next != '0)
         head_next = mem[rd_next];
   end

   // Entry storage; the array is not reset, only the pointers are
   always_ff @(posedge clk) begin
      if (do_write && !reset && !flush)
         mem[wr_ptr] <= entry;
   end

   // Pointers, fill level, flags and registered head
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
         if (reset)
            rti_out <= '0;
      end else begin
         if (do_write)
            wr_ptr <= wr_ptr + ADDR'(1);
         rd_ptr  <= rd_next;
         count   <= count_next;
         empty   <= (count_next == '0);
         full    <= (count_next == CNT_WIDTH'(DEPTH));
         rti_out <= head_next;
      end
   end

   // Error pulses and the sticky record of the last dropped sample
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_error      <= 1'b0;
         underflow_error     <= 1'b0;
         overflow_error_data <= '0;
      end else begin
         overflow_error  <= !flush && cap && full;
         underflow_error <= !flush && read && empty;
         if (!flush && cap && full)
            overflow_error_data <= entry;
      end
   end

endmodule

// File: tb/tb_rti_core.sv
// tb/tb_rti_core.sv - self-checking bench for rti_core against a queue model
module tb_rti_core;

   localparam int DEPTH = 1024;
   localparam int DW    = 64;
   localparam int EW    = 64 + DW;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset, flush, auto_start, sample_valid, read;
   logic [DW-1:0] sample_in;
   logic [63:0]   counter;
   logic [EW-1:0] rti_out, overflow_error_data;
   logic          empty, full, overflow_error, underflow_error;
   logic [CW-1:0] count;

   logic [EW-1:0] q [$];
   logic          m_ovf, m_unf, m_first;
   logic [EW-1:0] m_ovf_data;
   logic [DW-1:0] m_last;
   int            n_checks = 0;
   int            n_pass   = 0;

   rti_core #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .flush(flush), .auto_start(auto_start),
      .sample_valid(sample_valid), .sample_in(sample_in), .counter(counter),
      .read(read), .rti_out(rti_out), .empty(empty), .full(full), .count(count),
      .overflow_error(overflow_error), .overflow_error_data(overflow_error_data),
      .underflow_error(underflow_error)
   );

   always #5 clk = ~clk;

   // Advance the behavioural model with the current inputs, then let the DUT see the same edge
   task automatic tick();
      int   sz;
      logic c;
      sz    = q.size();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      if (reset) begin
         q.delete();
         m_ovf_data = '0;
         m_first    = 1'b1;
         m_last     = '0;
      end else if (flush) begin
         q.delete();
         m_first = 1'b1;
      end else begin
         c = sample_valid && auto_start;
`ifdef RTI_CHANGE_DETECT_EN
         c = c && (m_first || sample_in != m_last);
         if (c) begin
            m_first = 1'b0;
            m_last  = sample_in;
         end
`endif
         if (read && sz == 0) m_unf = 1'b1;
         if (c && sz == DEPTH) begin
            m_ovf      = 1'b1;
            m_ovf_data = {counter, sample_in};
         end
         if (read && sz > 0) void'(q.pop_front());
         if (c && sz < DEPTH) q.push_back({counter, sample_in});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else n_pass++;
      n_checks++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else n_pass++;
      n_checks++; if (count !== '0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
      n_checks++; if (rti_out !== '0) $display("FAIL reset_rti_out got %h want 0", rti_out); else n_pass++;
      n_checks++; if (overflow_error !== 1'b0 || underflow_error !== 1'b0)
         $display("FAIL reset_err got ovf=%b unf=%b want 0 0", overflow_error, underflow_error); else n_pass++;
      n_checks++; if (overflow_error_data !== '0) $display("FAIL reset_ovf_data got %h want 0", overflow_error_data); else n_pass++;
   endtask

   task automatic test_basic();
      auto_start   = 1'b1;
      counter      = 64'h100;
      sample_in    = 64'hA5;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      n_checks++; if (empty !== 1'b0 || count !== CW'(1))
         $display("FAIL basic_write got empty=%b count=%0d want 0 1", empty, count); else n_pass++;
      n_checks++; if (rti_out !== {64'h100, 64'hA5})
         $display("FAIL basic_head got %h want %h", rti_out, {64'h100, 64'hA5}); else n_pass++;
      read = 1'b1;
      tick();
      read = 1'b0;
      n_checks++; if (empty !== 1'b1 || count !== '0)
         $display("FAIL basic_read got empty=%b count=%0d want 1 0", empty, count); else n_pass++;
   endtask

   task automatic fill(input logic [63:0] base);
      sample_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         counter   = base + 64'(i);
         sample_in = {$urandom(), $urandom()};
         tick();
      end
      sample_valid = 1'b0;
   endtask

   task automatic test_fill_overflow();
      fill(64'h1000);
      n_checks++; if (full !== 1'b1 || count !== CW'(DEPTH))
         $display("FAIL fill_full got full=%b count=%0d want 1 %0d", full, count, DEPTH); else n_pass++;
      counter      = 64'h2000;
      sample_in    = 64'hDEAD;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      n_checks++; if (overflow_error !== 1'b1) $display("FAIL ovf_pulse got %b want 1", overflow_error); else n_pass++;
      n_checks++; if (overflow_error_data !== {64'h2000, 64'hDEAD})
         $display("FAIL ovf_data got %h want %h", overflow_error_data, {64'h2000, 64'hDEAD}); else n_pass++;
      n_checks++; if (count !== CW'(DEPTH)) $display("FAIL ovf_count got %0d want %0d", count, DEPTH); else n_pass++;
      tick();
      n_checks++; if (overflow_error !== 1'b0) $display("FAIL ovf_one_cycle got %b want 0", overflow_error); else n_pass++;
      read = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         n_checks++;
         if (rti_out !== q[0] || rti_out[EW-1:DW] !== 64'h1000 + 64'(i))
            $display("FAIL drain_%0d got %h want %h", i, rti_out, q[0]);
         else n_pass++;
         tick();
      end
      read = 1'b0;
      n_checks++; if (empty !== 1'b1 || count !== '0)
         $display("FAIL drain_end got empty=%b count=%0d want 1 0", empty, count); else n_pass++;
   endtask

   task automatic test_full_simul();
      fill(64'h3000);
      sample_valid = 1'b1;
      read         = 1'b1;
      counter      = 64'h4000;
      sample_in    = 64'hBEEF;
      tick();
      sample_valid = 1'b0;
      read         = 1'b0;
      n_checks++; if (count !== CW'(DEPTH - 1) || full !== 1'b0)
         $display("FAIL simul_count got count=%0d full=%b want %0d 0", count, full, DEPTH - 1); else n_pass++;
      n_checks++; if (overflow_error !== 1'b1 || underflow_error !== 1'b0)
         $display("FAIL simul_err got ovf=%b unf=%b want 1 0", overflow_error, underflow_error); else n_pass++;
      n_checks++; if (rti_out[EW-1:DW] !== 64'h3001 || rti_out !== q[0])
         $display("FAIL simul_head got %h want %h", rti_out, q[0]); else n_pass++;
      read = 1'b1;
      for (int i = 0; i < DEPTH + 4 && q.size() > 0; i++) tick();
      read = 1'b0;
      n_checks++; if (empty !== 1'b1 || q.size() != 0)
         $display("FAIL simul_drain got empty=%b model=%0d want 1 0", empty, q.size()); else n_pass++;
   endtask

   task automatic test_underflow();
      read = 1'b1;
      tick();
      read = 1'b0;
      n_checks++; if (underflow_error !== 1'b1) $display("FAIL unf_pulse got %b want 1", underflow_error); else n_pass++;
      n_checks++; if (count !== '0 || empty !== 1'b1)
         $display("FAIL unf_state got count=%0d empty=%b want 0 1", count, empty); else n_pass++;
      tick();
      n_checks++; if (underflow_error !== 1'b0) $display("FAIL unf_one_cycle got %b want 0", underflow_error); else n_pass++;
   endtask

   task automatic test_flush();
      sample_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         counter   = 64'h6000 + 64'(i);
         sample_in = 64'(i + 16);
         tick();
      end
      n_checks++; if (count !== CW'(5)) $display("FAIL flush_pre got %0d want 5", count); else n_pass++;
      flush     = 1'b1;
      sample_in = 64'h77;
      tick();
      flush        = 1'b0;
      sample_valid = 1'b0;
      n_checks++; if (count !== '0 || empty !== 1'b1)
         $display("FAIL flush_clear got count=%0d empty=%b want 0 1", count, empty); else n_pass++;
      n_checks++; if (overflow_error_data !== {64'h4000, 64'hBEEF})
         $display("FAIL flush_keep_ovf got %h want %h", overflow_error_data, {64'h4000, 64'hBEEF}); else n_pass++;
      n_checks++; if (overflow_error !== 1'b0 || underflow_error !== 1'b0)
         $display("FAIL flush_no_pulse got ovf=%b unf=%b want 0 0", overflow_error, underflow_error); else n_pass++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++; if (overflow_error_data !== '0) $display("FAIL reset_clears_ovf got %h want 0", overflow_error_data); else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 7000; i++) begin
         auto_start   = ($urandom_range(0, 7) != 0);
         sample_valid = $urandom_range(0, 1);
         sample_in    = 64'($urandom_range(0, 3));
         read         = (i < 4500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
         flush        = ($urandom_range(0, 999) == 0);
         counter      = 64'h10000 + 64'(i);
         tick();
         n_checks++; if (count !== CW'(q.size()))
            $display("FAIL rnd_count@%0d got %0d want %0d", i, count, q.size()); else n_pass++;
         n_checks++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH))
            $display("FAIL rnd_flags@%0d got empty=%b full=%b model=%0d", i, empty, full, q.size()); else n_pass++;
         n_checks++; if (overflow_error !== m_ovf || underflow_error !== m_unf)
            $display("FAIL rnd_err@%0d got ovf=%b unf=%b want %b %b", i, overflow_error, underflow_error, m_ovf, m_unf); else n_pass++;
         n_checks++; if (overflow_error_data !== m_ovf_data)
            $display("FAIL rnd_ovf_data@%0d got %h want %h", i, overflow_error_data, m_ovf_data); else n_pass++;
         if (q.size() > 0) begin
            n_checks++; if (rti_out !== q[0])
               $display("FAIL rnd_head@%0d got %h want %h", i, rti_out, q[0]); else n_pass++;
         end
      end
      auto_start   = 1'b0;
      sample_valid = 1'b0;
      read         = 1'b1;
      flush        = 1'b0;
      for (int i = 0; i < DEPTH + 4 && q.size() > 0; i++) tick();
      read = 1'b0;
      tick();
      n_checks++; if (empty !== 1'b1) $display("FAIL rnd_drain_after_stop got empty=%b want 1", empty); else n_pass++;
   endtask

`ifdef RTI_CHANGE_DETECT_EN
   task automatic test_change_detect();
      logic [EW-1:0] exp [3];
      logic [DW-1:0] vals [5];
      exp[0] = {64'h500, 64'h1};
      exp[1] = {64'h502, 64'h2};
      exp[2] = {64'h504, 64'h1};
      vals[0] = 64'h1; vals[1] = 64'h1; vals[2] = 64'h2; vals[3] = 64'h2; vals[4] = 64'h1;
      reset = 1'b1;
      tick();
      reset        = 1'b0;
      auto_start   = 1'b1;
      sample_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         counter   = 64'h500 + 64'(k);
         sample_in = vals[k];
         tick();
      end
      sample_valid = 1'b0;
      n_checks++; if (count !== CW'(3)) $display("FAIL cd_count got %0d want 3", count); else n_pass++;
      read = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n_checks++; if (rti_out !== exp[k]) $display("FAIL cd_entry_%0d got %h want %h", k, rti_out, exp[k]); else n_pass++;
         tick();
      end
      read = 1'b0;
   endtask
`endif

   initial begin
      reset = 1'b1; flush = 1'b0; auto_start = 1'b0; sample_valid = 1'b0; read = 1'b0;
      sample_in = '0; counter = '0;
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_first = 1'b1; m_ovf_data = '0; m_last = '0;
      test_reset();
      test_basic();
      test_fill_overflow();
      test_full_simul();
      test_underflow();
      test_flush();
      test_random();
`ifdef RTI_CHANGE_DETECT_EN
      test_change_detect();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
